soc_system_st_ready_latency_source: RTL
=======================================

Name: soc_system_st_ready_latency_source

Overview:
Transmit-side companion to the Avalon-ST timing adapter FIFO.
- Upstream source uses readyLatency 0. Downstream sink uses readyLatency = LATENCY.
- A sink asserting out_ready in cycle t accepts a beat only in cycle t+LATENCY. The block presents valid data in exactly that slot.
- All outputs to the sink are registered. Sits between an internal packet generator and any latency-N Avalon-ST sink in soc_system.

Parameters:
- DATA_WIDTH, 26, width of the in_data/out_data payload (packed sop/eop/channel/data as the system packs them).
- LATENCY, 2, downstream ready latency in cycles; legal range 1..4; out-of-range is a synthesis-time error.
- COUNT_WIDTH, 16, width of the beat and stall counters.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset (acts on negedge reset_n, release synchronous to clk).
- in_ready  out  1  upstream ready, readyLatency 0 semantics.
- in_valid  in  1  upstream valid.
- in_data  in  DATA_WIDTH  upstream payload.
- out_ready  in  1  downstream ready, readyLatency LATENCY semantics.
- out_valid  out  1  registered downstream valid.
- out_data  out  DATA_WIDTH  registered downstream payload.
- beat_count  out  COUNT_WIDTH  number of beats delivered downstream.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, beat_count=0.
  - Ready delay line all 0, so in_ready=0 for LATENCY>=2. For LATENCY=1, in_ready follows out_ready combinationally.
- Ready delay line: shift register rdy_d[LATENCY-2:0], with rdy_d[0] <= out_ready and rdy_d[k] <= rdy_d[k-1]. It is absent when LATENCY=1.
- in_ready:
  - LATENCY=1: in_ready = out_ready.
  - Otherwise: in_ready = rdy_d[LATENCY-2], i.e. out_ready from LATENCY-1 cycles earlier.
  - in_ready never depends combinationally on in_valid.
- Upstream transfer in cycle c (in_ready & in_valid) → out_valid=1 and out_data=in_data in cycle c+1, which is exactly LATENCY cycles after the enabling out_ready.
- No transfer in cycle c → out_valid=0 in cycle c+1. out_data holds its last value (no X, no clear).
- Latency: in_data to out_data is 1 cycle. out_ready to the first possible out_valid is LATENCY cycles.
- out_valid is never 1 in a cycle whose corresponding out_ready (LATENCY cycles earlier) was 0. This is the protocol invariant.
- beat_count increments by 1 on every cycle with out_valid=1. It wraps modulo 2^COUNT_WIDTH (0xFFFF → 0x0000) without a flag.
- out_ready toggling every cycle → out_valid pattern equals the out_ready pattern delayed by LATENCY, gated by in_valid.
- Reset mid-operation: in-flight ready history and any registered beat are discarded. After release, in_ready stays 0 for LATENCY-1 cycles even if out_ready=1 (LATENCY>=2).
- No internal storage beyond one output register. Back-pressure is purely via in_ready.

Optional Feature:
- Macro: SOC_SYSTEM_ST_STALL_COUNTER_EN.
- Defined:
  - Adds output stall_count [COUNT_WIDTH-1:0], reset 0.
  - Increments every cycle with in_valid=1 and in_ready=0.
  - Saturates at all-ones (does not wrap).
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package soc_system_st_pkg holds:
  - constants ST_MIN_READY_LATENCY=1 and ST_MAX_READY_LATENCY=4;
  - the default DATA_WIDTH=26 and COUNT_WIDTH=16;
  - a range-check function for LATENCY.
- One sub-module: soc_system_st_ready_delay (parameter DEPTH, input out_ready, output delayed ready, async active-low reset to 0). It is instantiated with DEPTH=LATENCY-1 when LATENCY>=2.

Test Plan:
- Reset/fill, LATENCY=2, out_ready=1 constant, in_valid=1: in_ready=0 for 1 cycle after reset release, then 1; first out_valid=1 at release+2 with out_data equal to the first in_data (0x0000001).
- Streaming, LATENCY=3, incrementing in_data 0..31, out_ready=1: 32 consecutive out_valid beats with data 0..31 in order; beat_count=32.
- Ready toggle, LATENCY=2, out_ready=1010…, in_valid=1: out_valid is exactly 0,0,1,0,1,0…, never 1 two cycles after out_ready=0; the invariant is checked every cycle.
- LATENCY=1 bypass: out_ready=0 → in_ready=0 in the same cycle; out_ready=1 with in_valid=1, data 0x3A5 → out_valid=1, out_data=0x3A5 next cycle.
- Mid-stream reset, LATENCY=4: assert reset_n low for 1 cycle during streaming → out_valid=0 and beat_count=0 immediately; in_ready=0 for 3 cycles after release; the stream resumes with no stale beat.
- With SOC_SYSTEM_ST_STALL_COUNTER_EN, in_valid=1, out_ready=0 for 10 cycles (LATENCY=2): stall_count=10. With beat_count preloaded to near wrap via 65536 beats, beat_count reads 0.

Source files
------------

// File: rtl/soc_system_st_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_st_pkg
// Description : Shared constants and helpers for the soc_system Avalon-ST
//               ready-latency blocks: legal ready-latency range, default
//               payload/counter widths and a latency range check.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_system_st_pkg;

  localparam int ST_MIN_READY_LATENCY   = 1;
  localparam int ST_MAX_READY_LATENCY   = 4;
  localparam int ST_DEFAULT_DATA_WIDTH  = 26;
  localparam int ST_DEFAULT_COUNT_WIDTH = 16;

  // True when a downstream ready latency can be served by the source.
  function automatic bit st_latency_in_range(input int latency);
    return (latency >= ST_MIN_READY_LATENCY) && (latency <= ST_MAX_READY_LATENCY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/soc_system_st_ready_delay.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_st_ready_delay
// Description : Shift register that delays the downstream ready by DEPTH
//               cycles. Clears to all-zero on reset so no stale ready
//               history survives a reset.
// Ports       : clk           - system clock (posedge)
//               reset_n       - asynchronous active-low reset
//               out_ready     - downstream ready, undelayed
//               delayed_ready - out_ready from DEPTH cycles earlier
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_st_ready_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic out_ready,
  output logic delayed_ready
);

  logic [DEPTH-1:0] rdy_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_d <= '0;
    end else begin
      rdy_d[0] <= out_ready;
      for (int k = 1; k < DEPTH; k++) begin
        rdy_d[k] <= rdy_d[k-1];
      end
    end
  end

  assign delayed_ready = rdy_d[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/soc_system_st_ready_latency_source.sv
`default_nettype none
// ============================================================================
// Module      : soc_system_st_ready_latency_source
// Description : Adapts a readyLatency-0 upstream source to a sink that uses
//               readyLatency = LATENCY. Upstream is granted a transfer only
//               in the cycle whose registered output lands exactly LATENCY
//               cycles after the sink's out_ready, so no beat storage beyond
//               the single output register is needed.
// Ports       : clk, reset_n            - clock / async active-low reset
//               in_ready/in_valid/in_data    - upstream (readyLatency 0)
//               out_ready/out_valid/out_data - downstream (readyLatency N)
//               beat_count              - beats delivered, wraps
//               stall_count             - upstream stall cycles, saturates
//                                         (only with SOC_SYSTEM_ST_STALL_COUNTER_EN)
// Options     : `define SOC_SYSTEM_ST_STALL_COUNTER_EN adds stall_count.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_system_st_ready_latency_source
  import soc_system_st_pkg::*;
#(
  parameter int DATA_WIDTH  = ST_DEFAULT_DATA_WIDTH,
  parameter int LATENCY     = 2,
  parameter int COUNT_WIDTH = ST_DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [COUNT_WIDTH-1:0] beat_count
`ifdef SOC_SYSTEM_ST_STALL_COUNTER_EN
  ,
  output logic [COUNT_WIDTH-1:0] stall_count
`endif
);

  if (!st_latency_in_range(LATENCY)) begin : g_latency_check
    $error("soc_system_st_ready_latency_source: LATENCY must be 1..4");
  end

  // The output register adds one cycle, so the ready seen upstream must be
  // out_ready delayed by LATENCY-1 cycles.
  if (LATENCY == 1) begin : g_bypass
    assign in_ready = out_ready;
  end else begin : g_delay
    soc_system_st_ready_delay #(
      .DEPTH (LATENCY - 1)
    ) u_ready_delay (
      .clk           (clk),
      .reset_n       (reset_n),
      .out_ready     (out_ready),
      .delayed_ready (in_ready)
    );
  end

  logic transfer;
  assign transfer = in_ready & in_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      beat_count <= '0;
    end else begin
      out_valid <= transfer;
      // Data holds between beats so the sink never sees a spurious change.
      if (transfer) begin
        out_data <= in_data;
      end
      if (out_valid) begin
        beat_count <= beat_count + COUNT_WIDTH'(1);
      end
    end
  end

`ifdef SOC_SYSTEM_ST_STALL_COUNTER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (in_valid && !in_ready && (stall_count != '1)) begin
      stall_count <= stall_count + COUNT_WIDTH'(1);
    end
  end
`else
  // Stall counter not built in this configuration.
`endif

endmodule
`default_nettype wire
